rvfpm_xif_issuer: RTL and testbench



---
 rtl/rvfpm_xif_issuer.sv | 174 +++++++++++++++++
 tb/tb_rvfpm_xif_issuer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfpm_xif_issuer.sv
// rvfpm_xif_issuer: buffers core FP requests, issues them to the FPU in ID order, and tracks
// outstanding IDs so that results or timeouts retire to the core with status.
module rvfpm_xif_issuer #(
    parameter int X_ID_WIDTH      = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_instr,
    input  logic [31:0]           req_xreg,
    input  logic [31:0]           req_mem,
    input  logic                  fpu_full,
    output logic                  fpu_enable,
    output logic [31:0]           fpu_instruction,
    output logic [X_ID_WIDTH-1:0] fpu_id,
    output logic [31:0]           fpu_data_fromXreg,
    output logic [31:0]           fpu_data_fromMem,
    input  logic                  fpu_res_valid,
    input  logic [X_ID_WIDTH-1:0] fpu_res_id,
    input  logic [31:0]           fpu_res_data,
    input  logic                  fpu_res_to_mem,
    output logic                  ret_valid,
    output logic [X_ID_WIDTH-1:0] ret_id,
    output logic [31:0]           ret_data,
    output logic                  ret_to_mem,
    output logic                  ret_error,
    output logic [X_ID_WIDTH:0]   outstanding,
    output logic                  busy
);
    localparam int SB = 1 << X_ID_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [X_ID_WIDTH:0] CAP = (X_ID_WIDTH+1)'(MAX_OUTSTANDING);
    localparam logic [AW-1:0] TMO = AW'(TIMEOUT_CYCLES);

    logic [95:0]           fifo_q [FIFO_DEPTH];
    logic [95:0]           fifo_d [FIFO_DEPTH];
    logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]           cnt_q, cnt_d;
    logic [X_ID_WIDTH-1:0] nid_q, nid_d;
    logic [SB-1:0]         sbv_q, sbv_d;
    logic [AW-1:0]         age_q [SB];
    logic [AW-1:0]         age_d [SB];
    logic [X_ID_WIDTH:0]   out_q, out_d;
    logic                  en_q, en_d;
    logic [95:0]           pay_q, pay_d;
    logic [X_ID_WIDTH-1:0] id_q, id_d;
    logic                  rv_q, rv_d;
    logic [X_ID_WIDTH-1:0] rid_q, rid_d;
    logic [31:0]           rdat_q, rdat_d;
    logic                  rmem_q, rmem_d, rerr_q, rerr_d;
    logic                  empty, push, issue, byp, hit, ok, to_hit, clr;
    logic [X_ID_WIDTH-1:0] to_idx, clr_idx;
    logic [95:0]           head;

    assign empty             = cnt_q == '0;
    assign req_ready         = cnt_q != FULL;
    assign busy              = !empty || out_q != '0;
    assign fpu_enable        = en_q;
    assign {fpu_instruction, fpu_data_fromXreg, fpu_data_fromMem} = pay_q;
    assign fpu_id            = id_q;
    assign ret_valid         = rv_q;
    assign ret_id            = rid_q;
    assign ret_data          = rdat_q;
    assign ret_to_mem        = rmem_q;
    assign ret_error         = rerr_q;
    assign outstanding       = out_q;

    always_comb begin
        fifo_d = fifo_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        nid_d  = nid_q;
        sbv_d  = sbv_q;
        pay_d  = pay_q;
        id_d   = id_q;
        rid_d  = rid_q;
        rdat_d = rdat_q;
        rmem_d = rmem_q;
        rerr_d = rerr_q;
        to_hit = 1'b0;
        to_idx = '0;
        // descending scan so the lowest timed-out index wins
        for (int i = SB - 1; i >= 0; i--) begin
            age_d[i] = (sbv_q[i] && age_q[i] != TMO) ? age_q[i] + AW'(1) : age_q[i];
            if (sbv_q[i] && age_q[i] == TMO) begin
                to_hit = 1'b1;
                to_idx = X_ID_WIDTH'(i);
            end
        end
        push    = req_valid && req_ready && !flush;
        head    = empty ? {req_instr, req_xreg, req_mem} : fifo_q[rd_q];
        issue   = (!empty || push) && !fpu_full && out_q < CAP && !sbv_q[nid_q] && !flush;
        byp     = issue && empty;
        hit     = sbv_q[fpu_res_id];
        ok      = fpu_res_valid && hit;
        rv_d    = !flush && (fpu_res_valid || to_hit);
        clr     = rv_d && (ok || !fpu_res_valid);
        clr_idx = fpu_res_valid ? fpu_res_id : to_idx;
        en_d    = issue;
        if (push && !byp) begin
            fifo_d[wr_q] = {req_instr, req_xreg, req_mem};
            wr_d         = wr_q + PW'(1);
        end
        if (issue) begin
            pay_d        = head;
            id_d         = nid_q;
            nid_d        = nid_q + X_ID_WIDTH'(1);
            sbv_d[nid_q] = 1'b1;
            age_d[nid_q] = '0;
            rd_d         = byp ? rd_q : rd_q + PW'(1);
        end
        cnt_d = cnt_q + (PW+1)'(push && !byp) - (PW+1)'(issue && !byp);
        if (rv_d) begin
            rid_d  = clr_idx;
            rdat_d = ok ? fpu_res_data : '0;
            rmem_d = ok && fpu_res_to_mem;
            rerr_d = !ok;
        end
        if (clr) sbv_d[clr_idx] = 1'b0;
        out_d = out_q + (X_ID_WIDTH+1)'(issue) - (X_ID_WIDTH+1)'(clr);
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
            sbv_d = '0;
            out_d = '0;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            for (int i = 0; i < SB; i++) age_q[i] <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            nid_q  <= '0;
            sbv_q  <= '0;
            out_q  <= '0;
            en_q   <= 1'b0;
            pay_q  <= '0;
            id_q   <= '0;
            rv_q   <= 1'b0;
            rid_q  <= '0;
            rdat_q <= '0;
            rmem_q <= 1'b0;
            rerr_q <= 1'b0;
        end else begin
            fifo_q <= fifo_d;
            age_q  <= age_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            nid_q  <= nid_d;
            sbv_q  <= sbv_d;
            out_q  <= out_d;
            en_q   <= en_d;
            pay_q  <= pay_d;
            id_q   <= id_d;
            rv_q   <= rv_d;
            rid_q  <= rid_d;
            rdat_q <= rdat_d;
            rmem_q <= rmem_d;
            rerr_q <= rerr_d;
        end
    end
endmodule

// File: tb/tb_rvfpm_xif_issuer.sv
// tb_rvfpm_xif_issuer: directed scenarios with issue/retire scoreboards for rvfpm_xif_issuer.
module tb_rvfpm_xif_issuer;
    localparam int XW = 4;
    localparam int T  = 64;

    logic          ck = 1'b0, rst = 1'b1, flush = 1'b0, req_valid = 1'b0, fpu_full = 1'b0;
    logic [31:0]   req_instr = '0, req_xreg = '0, req_mem = '0, fpu_res_data = '0;
    logic          fpu_res_valid = 1'b0, fpu_res_to_mem = 1'b0;
    logic [XW-1:0] fpu_res_id = '0;
    logic          req_ready, fpu_enable, ret_valid, ret_to_mem, ret_error, busy;
    logic [31:0]   fpu_instruction, fpu_data_fromXreg, fpu_data_fromMem, ret_data;
    logic [XW-1:0] fpu_id, ret_id;
    logic [XW:0]   outstanding;

    rvfpm_xif_issuer dut (
        .ck(ck), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_xreg(req_xreg), .req_mem(req_mem), .fpu_full(fpu_full),
        .fpu_enable(fpu_enable), .fpu_instruction(fpu_instruction), .fpu_id(fpu_id),
        .fpu_data_fromXreg(fpu_data_fromXreg), .fpu_data_fromMem(fpu_data_fromMem),
        .fpu_res_valid(fpu_res_valid), .fpu_res_id(fpu_res_id), .fpu_res_data(fpu_res_data),
        .fpu_res_to_mem(fpu_res_to_mem), .ret_valid(ret_valid), .ret_id(ret_id),
        .ret_data(ret_data), .ret_to_mem(ret_to_mem), .ret_error(ret_error),
        .outstanding(outstanding), .busy(busy)
    );

    always #5 ck = ~ck;

    typedef struct packed {logic [31:0] instr, xreg, mem; logic [XW-1:0] id;} iss_t;
    typedef struct packed {logic [XW-1:0] id; logic [31:0] data; logic tm, err;} ret_t;

    iss_t        iq[$];
    ret_t        rq[$];
    logic [15:0] m_live = '0;
    int          m_nid = 0, n_iss = 0, n0 = 0, pass_n = 0, tot_n = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tot_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        iss_t e;
        ret_t r;
        @(posedge ck);
        #1;
        if (fpu_enable) begin
            n_iss++;
            if (iq.size() == 0) chk("unexp_issue", fpu_enable, 0);
            else begin
                e = iq.pop_front();
                chk("iss_id", fpu_id, e.id);
                chk("iss_instr", fpu_instruction, e.instr);
                chk("iss_xreg", fpu_data_fromXreg, e.xreg);
                chk("iss_mem", fpu_data_fromMem, e.mem);
                m_live[e.id] = 1'b1;
            end
        end
        if (ret_valid) begin
            if (rq.size() == 0) chk("unexp_ret", ret_valid, 0);
            else begin
                r = rq.pop_front();
                chk("ret_id", ret_id, r.id);
                chk("ret_data", ret_data, r.data);
                chk("ret_to_mem", ret_to_mem, r.tm);
                chk("ret_error", ret_error, r.err);
            end
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] x, input logic [31:0] m);
        iss_t e;
        bit   acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_instr = i;
        req_xreg  = x;
        req_mem   = m;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = req_ready;
            if (acc) begin
                e.instr = i;
                e.xreg  = x;
                e.mem   = m;
                e.id    = XW'(m_nid);
                iq.push_back(e);
                m_nid++;
            end
            cyc();
        end
        if (!acc) chk("push_acc", req_ready, 1);
        req_valid = 1'b0;
    endtask

    task automatic res(input logic [XW-1:0] id, input logic [31:0] d, input logic tm);
        ret_t r;
        bit   known;
        known = m_live[id];
        if (known) m_live[id] = 1'b0;
        r.id   = id;
        r.data = known ? d : '0;
        r.tm   = known && tm;
        r.err  = !known;
        rq.push_back(r);
        fpu_res_valid  = 1'b1;
        fpu_res_id     = id;
        fpu_res_data   = d;
        fpu_res_to_mem = tm;
        cyc();
        fpu_res_valid = 1'b0;
        chk("ret_lat", ret_valid, 1);
    endtask

    task automatic clear_model();
        iq.delete();
        rq.delete();
        m_live = '0;
        m_nid  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        @(posedge ck);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge ck);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_en", fpu_enable, 0);
        chk("rst_payload", {fpu_instruction, fpu_data_fromXreg, fpu_data_fromMem, fpu_id}, 0);
        chk("rst_ret", {ret_valid, ret_id, ret_data, ret_to_mem, ret_error}, 0);
        chk("rst_out", outstanding, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        push(32'h0020_80D3, 32'h5, 32'h0);
        chk("t1_lat", fpu_enable, 1);
        chk("t1_out1", outstanding, 1);
        res(0, 32'h4040_0000, 1'b0);
        chk("t1_out0", outstanding, 0);
        chk("t1_busy", busy, 0);

        do_reset();
        fpu_full = 1'b1;
        n0 = n_iss;
        for (int k = 0; k < 4; k++) push(32'h100 + k, 32'h10 + k, 32'h20 + k);
        chk("bp_ready", req_ready, 0);
        chk("bp_noiss", n_iss - n0, 0);
        fpu_full = 1'b0;
        push(32'h104, 32'h14, 32'h24);
        repeat (3) cyc();
        chk("bp_iss", n_iss - n0, 5);
        chk("bp_out", outstanding, 5);
        for (int k = 4; k >= 0; k--) res(XW'(k), 32'hA0 + k, k[0]);
        chk("bp_out0", outstanding, 0);

        do_reset();
        n0 = n_iss;
        for (int k = 0; k < 9; k++) push(32'h200 + k, k, 32'h0);
        repeat (2) cyc();
        chk("cap_stall", n_iss - n0, 8);
        chk("cap_out", outstanding, 8);
        res(3, 32'h33, 1'b0);
        chk("cap_same", fpu_enable, 0);
        cyc();
        chk("cap_iss", fpu_enable, 1);
        chk("cap_id", fpu_id, 8);
        for (int k = 0; k < 9; k++) if (k != 3) res(XW'(k), 32'hB0 + k, 1'b0);
        chk("cap_out0", outstanding, 0);

        do_reset();
        for (int k = 0; k < 8; k++) push(32'h300 + k, 0, 0);
        for (int k = 1; k < 8; k++) res(XW'(k), k, 1'b0);
        for (int k = 8; k < 15; k++) push(32'h300 + k, 0, 0);
        for (int k = 8; k < 15; k++) res(XW'(k), k, 1'b0);
        push(32'h30F, 0, 0);
        res(15, 32'hF, 1'b1);
        n0 = n_iss;
        push(32'h310, 0, 0);
        repeat (3) cyc();
        chk("wrap_stall", n_iss - n0, 0);
        chk("wrap_busy", busy, 1);
        res(0, 32'hC0, 1'b0);
        cyc();
        chk("wrap_iss", fpu_enable, 1);
        chk("wrap_id", fpu_id, 0);
        res(0, 32'hC1, 1'b0);
        chk("wrap_out0", outstanding, 0);

        do_reset();
        push(32'h400, 0, 0);
        chk("to_iss", fpu_enable, 1);
        repeat (T) cyc();
        rq.push_back('{id: 0, data: 0, tm: 0, err: 1});
        m_live[0] = 1'b0;
        cyc();
        chk("to_at", ret_valid, 1);
        chk("to_out", outstanding, 0);
        res(0, 32'h4444, 1'b1);
        chk("unk_out", outstanding, 0);

        do_reset();
        for (int k = 0; k < 3; k++) push(32'h500 + k, 0, 0);
        fpu_full = 1'b1;
        for (int k = 3; k < 5; k++) push(32'h500 + k, 0, 0);
        chk("fl_busy1", busy, 1);
        chk("fl_out3", outstanding, 3);
        flush = 1'b1;
        fpu_res_valid = 1'b1;
        fpu_res_id = 1;
        m_nid -= iq.size();
        iq.delete();
        m_live = '0;
        cyc();
        flush = 1'b0;
        fpu_res_valid = 1'b0;
        chk("fl_out0", outstanding, 0);
        chk("fl_busy0", busy, 0);
        chk("fl_noret", ret_valid, 0);
        fpu_full = 1'b0;
        repeat (2) cyc();
        push(32'h5FF, 1, 2);
        chk("fl_nid", fpu_id, 3);

        rst = 1'b1;
        #1;
        chk("ar_en", fpu_enable, 0);
        chk("ar_payload", {fpu_instruction, fpu_data_fromXreg, fpu_data_fromMem, fpu_id}, 0);
        chk("ar_out", outstanding, 0);
        chk("ar_ready", req_ready, 1);
        chk("ar_busy", busy, 0);
        chk("ar_ret", {ret_valid, ret_id, ret_data, ret_to_mem, ret_error}, 0);
        clear_model();
        @(posedge ck);
        #1;
        rst = 1'b0;
        repeat (3) cyc();
        chk("ar_quiet", {fpu_enable, ret_valid, busy}, 0);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
